// File: rtl/behavioral_full_adder.sv
// Purpose: registered ripple-carry full adder, {carryout, sum} = a + b + carryin at WIDTH+1 bits.
// Latency: 1 cycle from sampled in_valid to out_valid; one add per cycle.
// Backpressure: none; every sampled valid input yields exactly one valid output.
//
// Ports:
//   sum, carryout      registered result (held while in_valid=0)
//   a, b, carryin      unsigned operands and carry into the LSB
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   in_valid           inputs sampled on this edge when high
//   out_valid          sum/carryout carry a fresh result this cycle
//   overflow           (only with BEHAVIORAL_FULL_ADDER_OVERFLOW_EN) two's-complement
//                      signed overflow, registered alongside sum
//
// Optional feature macro: BEHAVIORAL_FULL_ADDER_OVERFLOW_EN
module behavioral_full_adder #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             out_valid
`ifdef BEHAVIORAL_FULL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("behavioral_full_adder: WIDTH must be in 1..64");
    end

    // c[i] is the carry into bit i; c[0] is carryin, c[WIDTH] is carryout.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    // Plain ripple chain: each cell consumes the carry of the cell below it.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = carryin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    // Result registers load only on valid cycles, so garbage on the operand
    // inputs during idle cycles never reaches the held outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carryout  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= s;
                carryout <= c[WIDTH];
            end
        end
    end

`ifdef BEHAVIORAL_FULL_ADDER_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid) begin
            overflow <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_behavioral_full_adder.sv
module tb_behavioral_full_adder;

    typedef struct {
        bit              vld;
        longint unsigned sum;
        bit              co;
        bit              ov;
    } exp_t;

    logic       clk;
    logic       rst_n;

    // WIDTH=1 instance
    logic [0:0] a_1, b_1, sum_1;
    logic       cin_1, vld_in_1, vld_out_1, co_1;
    // WIDTH=8 instance
    logic [7:0] a_8, b_8, sum_8;
    logic       cin_8, vld_in_8, vld_out_8, co_8;
`ifdef BEHAVIORAL_FULL_ADDER_OVERFLOW_EN
    logic       ov_1, ov_8;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q1[$];
    exp_t q8[$];
    exp_t h1, h8;

    behavioral_full_adder #(.WIDTH(1)) u1 (
        .sum(sum_1), .carryout(co_1), .a(a_1), .b(b_1), .carryin(cin_1),
        .clk(clk), .rst_n(rst_n), .in_valid(vld_in_1), .out_valid(vld_out_1)
`ifdef BEHAVIORAL_FULL_ADDER_OVERFLOW_EN
        , .overflow(ov_1)
`endif
    );

    behavioral_full_adder #(.WIDTH(8)) u8 (
        .sum(sum_8), .carryout(co_8), .a(a_8), .b(b_8), .carryin(cin_8),
        .clk(clk), .rst_n(rst_n), .in_valid(vld_in_8), .out_valid(vld_out_8)
`ifdef BEHAVIORAL_FULL_ADDER_OVERFLOW_EN
        , .overflow(ov_8)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: arithmetic sum at w+1 bits; signed overflow from the
    // two's-complement value range rather than from carries.
    function automatic exp_t model(input int w, input longint unsigned a, input longint unsigned b,
                                   input bit c, input bit v);
        exp_t            e;
        longint unsigned full;
        longint          sa, sb, sr, half;
        full  = a + b + longint'(c);
        e.vld = v;
        e.sum = full & ((64'd1 << w) - 1);
        e.co  = bit'((full >> w) & 1);
        half  = longint'(64'd1 << (w - 1));
        sa    = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
        sb    = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
        sr    = sa + sb + longint'(c);
        e.ov  = (sr > half - 1) || (sr < -half);
        return e;
    endfunction

    task automatic drive(input bit v1, input bit a1, input bit b1, input bit c1,
                         input bit v8, input bit [7:0] a8, input bit [7:0] b8, input bit c8);
        vld_in_1 = v1; a_1 = a1; b_1 = b1; cin_1 = c1;
        vld_in_8 = v8; a_8 = a8; b_8 = b8; cin_8 = c8;
        @(posedge clk);
        q1.push_back(model(1, 64'(a1), 64'(b1), c1, v1));
        q8.push_back(model(8, 64'(a8), 64'(b8), c8, v8));
        #1;
    endtask

    task automatic rnd_cycle();
        drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sum1"}, sum_1, 0);
        chk({tag, "_co1"},  co_1, 0);
        chk({tag, "_vld1"}, vld_out_1, 0);
        chk({tag, "_sum8"}, sum_8, 0);
        chk({tag, "_co8"},  co_8, 0);
        chk({tag, "_vld8"}, vld_out_8, 0);
`ifdef BEHAVIORAL_FULL_ADDER_OVERFLOW_EN
        chk({tag, "_ov1"}, ov_1, 0);
        chk({tag, "_ov8"}, ov_8, 0);
`endif
    endtask

    // Monitors: one expectation per cycle; out_valid must match exactly, and
    // the data must equal the latest valid result (held across idle cycles).
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q1.size() > 0) begin
            e = q1.pop_front();
            chk("u1_out_valid", vld_out_1, e.vld);
            if (e.vld) h1 = e;
            chk("u1_sum", sum_1, h1.sum);
            chk("u1_carryout", co_1, h1.co);
`ifdef BEHAVIORAL_FULL_ADDER_OVERFLOW_EN
            chk("u1_overflow", ov_1, h1.ov);
`endif
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q8.size() > 0) begin
            e = q8.pop_front();
            chk("u8_out_valid", vld_out_8, e.vld);
            if (e.vld) h8 = e;
            chk("u8_sum", sum_8, h8.sum);
            chk("u8_carryout", co_8, h8.co);
`ifdef BEHAVIORAL_FULL_ADDER_OVERFLOW_EN
            chk("u8_overflow", ov_8, h8.ov);
`endif
        end
    end

    initial begin
        h1 = '{vld: 1'b0, sum: 0, co: 1'b0, ov: 1'b0};
        h8 = '{vld: 1'b0, sum: 0, co: 1'b0, ov: 1'b0};
        rst_n = 1'b0;
        vld_in_1 = 0; a_1 = 0; b_1 = 0; cin_1 = 0;
        vld_in_8 = 0; a_8 = 0; b_8 = 0; cin_8 = 0;
        #2;
        chk_zero("reset_state");
        #10 rst_n = 1'b1;   // released between edges (t=12)

        // Exhaustive WIDTH=1 truth table in the {a,b,carryin} order 000,100,010,001,110,011,101,111
        drive(1, 0, 0, 0, 1, 8'h00, 8'h00, 0);
        drive(1, 1, 0, 0, 1, 8'h12, 8'h34, 0);
        drive(1, 0, 1, 0, 1, 8'h80, 8'h80, 0);
        drive(1, 0, 0, 1, 1, 8'h80, 8'h7F, 1);
        drive(1, 1, 1, 0, 0, 8'hFF, 8'hFF, 1);
        drive(1, 0, 1, 1, 1, 8'hFF, 8'hFF, 1);
        drive(1, 1, 0, 1, 1, 8'h01, 8'h01, 0);
        drive(1, 1, 1, 1, 1, 8'hC0, 8'hC0, 0);

        // Hold: S1 C0 captured, then junk inputs with in_valid low
        drive(1, 1, 0, 0, 1, 8'h40, 8'h40, 0);
        drive(0, 1, 1, 1, 0, 8'hFF, 8'hFF, 1);
        drive(0, 0, 1, 0, 0, 8'h13, 8'h57, 0);

        // Signed-overflow and wrap-around corners on WIDTH=8
        drive(1, 0, 1, 1, 1, 8'h7F, 8'h01, 0);
        drive(1, 1, 0, 1, 1, 8'hFF, 8'h00, 1);
        drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 0);

        // Asynchronous reset between edges after a 1+1+1 capture
        drive(1, 1, 1, 1, 1, 8'hAA, 8'h55, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        q1.delete();
        q8.delete();
        h1 = '{vld: 1'b0, sum: 0, co: 1'b0, ov: 1'b0};
        h8 = '{vld: 1'b0, sum: 0, co: 1'b0, ov: 1'b0};
        vld_in_1 = 1; vld_in_8 = 1;   // must be ignored while in reset
        @(posedge clk);
        #1 chk_zero("reset_held");
        #2 rst_n = 1'b1;
        drive(0, 1, 1, 1, 0, 8'hFF, 8'hFF, 1);   // nothing sampled: out_valid stays 0, outputs 0
        drive(1, 1, 1, 0, 1, 8'h01, 8'hFF, 0);   // first capture after release

        for (int i = 0; i < 200; i++) rnd_cycle();

        drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        @(negedge clk);
        #1 chk("scoreboard_drained", q1.size() + q8.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
